operand_fetch: RTL
==================

Name: operand_fetch

Overview:
- Read-side counterpart of the write-back destination path: decodes source fields of the 8-bit instruction, reads the 4x8 register file, and issues operands to execute.
- Owns the register file storage, the write-back port and a per-register busy scoreboard.
- Stalls issue on read-after-write hazards against instructions whose write-back has not yet arrived.
- Sits between instruction fetch and the ALU stage.

Parameters:
- DATA_WIDTH, 8, register and operand width
- ADDR_WIDTH, 2, register index width
- NUM_REGS, 4, register count (2**ADDR_WIDTH)

Ports:
- Clk  input  1  clock, rising edge
- Clear  input  1  asynchronous, active-low reset
- Instr_Valid  input  1  instruction present on Instruction
- Instruction  input  8  [7:6] opcode, [5:4] rs, [3:2] rt, [1:0] rd
- RegDst  input  1  destination select for the issued instruction: 1 = rd, 0 = rt
- Issue_RegWrite  input  1  issued instruction will write back
- Instr_Ready  output  1  instruction accepted this cycle when high with Instr_Valid
- Out_Valid  output  1  operand bundle valid
- Out_Ready  input  1  execute stage consumes bundle
- Read_Data1  output  DATA_WIDTH  value of rs
- Read_Data2  output  DATA_WIDTH  value of rt
- Out_Dest  output  ADDR_WIDTH  destination index of the issued instruction
- RegWrite  input  1  write-back strobe
- Write_Register  input  ADDR_WIDTH  write-back index
- Write_Data  input  DATA_WIDTH  write-back value

Behaviour:
- Clear low (async): all registers, busy bits, Out_Valid, Read_Data1/2 and Out_Dest go to 0. Instr_Ready is 0 while Clear is low.
- Clear mid-operation discards any in-flight bundle and all busy state; no write-back is lost beyond that edge.
- Write-back: at posedge with RegWrite=1, regs[Write_Register] <= Write_Data and busy[Write_Register] <= 0.
  - Writes are accepted regardless of stall state.
  - Busy is cleared whether or not the register was marked busy.
- Hazard: hz = (busy[rs] and not bypass(rs)) or (busy[rt] and not bypass(rt)).
  - bypass(x) = RegWrite and Write_Register==x in the same cycle.
- Slot free: free = not Out_Valid or Out_Ready.
- Instr_Ready = free and not hz; combinational, 0 in reset.
- Accept (Instr_Valid and Instr_Ready) at posedge:
  - Read_Data1/2 load from the register file. A same-cycle write-back to the same index forwards Write_Data.
  - Out_Dest = RegDst ? Instruction[1:0] : Instruction[3:2].
  - Out_Valid <= 1.
  - If Issue_RegWrite: busy[Out_Dest] <= 1.
- Same register set busy by an accept and cleared by write-back on the same edge: set wins. This is the newer producer.
- No accept and Out_Ready: Out_Valid <= 0. Outputs hold their value when Out_Valid=1 and Out_Ready=0.
- Latency: accept to Out_Valid is 1 cycle. Back-to-back accepts are allowed when Out_Ready=1.
- An instruction whose rs==rt==busy register stalls until its write-back. With bypass it issues on the write-back cycle.

Optional Feature:
- Macro: OPERAND_FETCH_ZERO_REG_EN.
- Defined: register 0 reads as 0 and is never marked busy. Writes to index 0 are dropped, and bypass never forwards to index 0.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Shared package holds:
  - DATA_WIDTH/ADDR_WIDTH constants
  - instruction field positions (OP_MSB, RS_MSB, RT_MSB, RD_MSB)
  - operand bundle typedef {Read_Data1, Read_Data2, Out_Dest}
- One natural sub-module: regfile_2r1w (storage plus write-through bypass). Scoreboard and handshake stay in operand_fetch.

Test Plan:
- Reset: Clear low mid-run with busy[2]=1, Out_Valid=1 -> all outputs 0, busy cleared. After release, an instruction reading r2 issues without stall.
- Write then read: RegWrite r1=8'h5A, next cycle issue Instruction=8'b00_01_00_11 -> Read_Data1=8'h5A, Read_Data2=0, Out_Valid=1 one cycle after accept.
- Bypass: same-cycle RegWrite r3=8'hC3 and issue rs=r3 -> Read_Data1=8'hC3, no stall.
- RAW stall: issue RegDst=1, rd=2, Issue_RegWrite=1, then instruction with rt=2 -> Instr_Ready=0 until RegWrite r2=8'h11 arrives; accepts that cycle with Read_Data2=8'h11.
- Backpressure: Out_Ready=0 for 3 cycles with Out_Valid=1 -> Instr_Ready=0, Read_Data/Out_Dest stable. Out_Ready=1 -> next bundle follows without a bubble.
- Set/clear collision: write-back to r1 on the same edge an issue marks r1 busy -> busy[1]=1 afterwards; a reader of r1 stalls. With the macro defined, an issue writing r0 never stalls a reader of r0, which reads 0.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared widths, instruction field positions and operand bundle type
package operand_fetch_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 2;
  localparam int NUM_REGS = 1 << ADDR_WIDTH;
  localparam int OP_MSB = 7;
  localparam int RS_MSB = 5;
  localparam int RT_MSB = 3;
  localparam int RD_MSB = 1;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] Read_Data1;
    logic [DATA_WIDTH-1:0] Read_Data2;
    logic [ADDR_WIDTH-1:0] Out_Dest;
  } bundle_t;
endpackage

// File: rtl/operand_fetch_regfile_2r1w.sv
// regfile_2r1w: two-read one-write register file with write-through bypass
// OPERAND_FETCH_ZERO_REG_EN makes register 0 a hard-wired zero.
module regfile_2r1w #(
  parameter int DATA_WIDTH = operand_fetch_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = operand_fetch_pkg::ADDR_WIDTH,
  parameter int NUM_REGS = operand_fetch_pkg::NUM_REGS
) (
  input  logic                  Clk,
  input  logic                  Clear,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);
`ifdef OPERAND_FETCH_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic wr_en;
  assign wr_en = we && !(ZR && wa == '0);
  always_ff @(posedge Clk or negedge Clear)
    if (!Clear) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (wr_en) regs[wa] <= wd;
  assign rd1 = (ZR && ra1 == '0) ? '0 : (wr_en && wa == ra1) ? wd : regs[ra1];
  assign rd2 = (ZR && ra2 == '0) ? '0 : (wr_en && wa == ra2) ? wd : regs[ra2];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: decodes sources, reads the register file, tracks busy registers and issues operands
// OPERAND_FETCH_ZERO_REG_EN makes register 0 read as zero and never busy.
module operand_fetch #(
  parameter int DATA_WIDTH = operand_fetch_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = operand_fetch_pkg::ADDR_WIDTH,
  parameter int NUM_REGS = operand_fetch_pkg::NUM_REGS
) (
  input  logic                  Clk,
  input  logic                  Clear,
  input  logic                  Instr_Valid,
  input  logic [7:0]            Instruction,
  input  logic                  RegDst,
  input  logic                  Issue_RegWrite,
  output logic                  Instr_Ready,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic [DATA_WIDTH-1:0] Read_Data1,
  output logic [DATA_WIDTH-1:0] Read_Data2,
  output logic [ADDR_WIDTH-1:0] Out_Dest,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] Write_Register,
  input  logic [DATA_WIDTH-1:0] Write_Data
);
  import operand_fetch_pkg::*;
`ifdef OPERAND_FETCH_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  logic [ADDR_WIDTH-1:0] rs, rt, rd, dest;
  logic [DATA_WIDTH-1:0] rd1, rd2;
  logic [NUM_REGS-1:0] busy, busy_nx;
  logic hz, accept, unused_op;
  bundle_t out_q;
  assign rs = Instruction[RS_MSB -: ADDR_WIDTH];
  assign rt = Instruction[RT_MSB -: ADDR_WIDTH];
  assign rd = Instruction[RD_MSB -: ADDR_WIDTH];
  assign unused_op = ^Instruction[OP_MSB -: 2];
  assign dest = RegDst ? rd : rt;
  // a write-back landing this cycle resolves the hazard through the bypass
  assign hz = (busy[rs] && !(RegWrite && Write_Register == rs)) ||
              (busy[rt] && !(RegWrite && Write_Register == rt));
  assign Instr_Ready = Clear && (!Out_Valid || Out_Ready) && !hz;
  assign accept = Instr_Valid && Instr_Ready;
  regfile_2r1w #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)) u_rf (
    .Clk(Clk), .Clear(Clear), .we(RegWrite), .wa(Write_Register), .wd(Write_Data),
    .ra1(rs), .ra2(rt), .rd1(rd1), .rd2(rd2)
  );
  // the newly issued producer wins over a same-edge write-back clear
  always_comb begin
    busy_nx = busy;
    if (RegWrite) busy_nx[Write_Register] = 1'b0;
    if (accept && Issue_RegWrite && !(ZR && dest == '0)) busy_nx[dest] = 1'b1;
  end
  always_ff @(posedge Clk or negedge Clear)
    if (!Clear) begin
      busy <= '0;
      Out_Valid <= 1'b0;
      out_q <= '0;
    end else begin
      busy <= busy_nx;
      Out_Valid <= accept || (Out_Valid && !Out_Ready);
      if (accept) out_q <= '{Read_Data1: rd1, Read_Data2: rd2, Out_Dest: dest};
    end
  assign Read_Data1 = out_q.Read_Data1;
  assign Read_Data2 = out_q.Read_Data2;
  assign Out_Dest = out_q.Out_Dest;
endmodule
